// File: rtl/branch_pkg.sv
// branch_pkg: shared funct3 encodings, FSM states and helpers for branch_cmp_seq
package branch_pkg;
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic is_signed(input logic [2:0] f3);
    return f3[2:1] == 2'b10;
  endfunction
endpackage

// File: rtl/branch_cmp_seq_slice.sv
// cmp_slice: W-bit magnitude comparator chained from 4-bit cells, LSB cell first
module cmp_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_gt,
  input  logic         i_lt,
  input  logic         i_eq,
  output logic         o_gt,
  output logic         o_lt,
  output logic         o_eq
);
  localparam int N = W / 4;
  logic [N:0] w_gt, w_lt, w_eq;
  assign w_gt[0] = i_gt;
  assign w_lt[0] = i_lt;
  assign w_eq[0] = i_eq;
  for (genvar g = 0; g < N; g++) begin : g_cell
    logic [3:0] w_a, w_b;
    assign w_a = i_a[g*4 +: 4];
    assign w_b = i_b[g*4 +: 4];
    // a higher nibble decides on its own; lower history only passes through on a tie
    assign w_gt[g+1] = (w_a > w_b) | ((w_a == w_b) & w_gt[g]);
    assign w_lt[g+1] = (w_a < w_b) | ((w_a == w_b) & w_lt[g]);
    assign w_eq[g+1] = (w_a == w_b) & w_eq[g];
  end
  assign o_gt = w_gt[N];
  assign o_lt = w_lt[N];
  assign o_eq = w_eq[N];
endmodule

// File: rtl/branch_cmp_seq.sv
// branch_cmp_seq: multi-cycle RV64 branch condition unit, one SLICE-bit compare per cycle
module branch_cmp_seq
  import branch_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int SLICE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic            out_illegal,
  output logic            out_gt,
  output logic            out_lt,
  output logic            out_eq
);
  localparam int NSLICE = XLEN / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  if (XLEN % SLICE != 0 || SLICE % 4 != 0) begin : g_bad_params
    $error("branch_cmp_seq: XLEN must be a multiple of SLICE and SLICE a multiple of 4");
  end
  state_t          r_state;
  logic [XLEN-1:0] r_a, r_b;
  logic [2:0]      r_f3;
  logic [IW-1:0]   r_idx;
  logic            r_gt, r_lt, r_eq;
  logic            w_gt, w_lt, w_eq, w_taken;
  logic [XLEN-1:0] w_flip;
  assign w_flip = {is_signed(in_funct3), {(XLEN-1){1'b0}}};
  // operands shift right each cycle so the current slice always sits in the low bits
  cmp_slice #(.W(SLICE)) u_slice (
    .i_a (r_a[SLICE-1:0]),
    .i_b (r_b[SLICE-1:0]),
    .i_gt(r_gt),
    .i_lt(r_lt),
    .i_eq(r_eq),
    .o_gt(w_gt),
    .o_lt(w_lt),
    .o_eq(w_eq)
  );
  always_comb
    w_taken = (r_f3 == BR_EQ) ? w_eq :
              (r_f3 == BR_NE) ? !w_eq :
              (r_f3 == BR_LT || r_f3 == BR_LTU) ? w_lt :
              (r_f3 == BR_GE || r_f3 == BR_GEU) ? !w_lt : 1'b0;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_taken   <= 1'b0;
      out_illegal <= 1'b0;
      out_gt      <= 1'b0;
      out_lt      <= 1'b0;
      out_eq      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (in_valid) begin
          r_a      <= in_rs1 ^ w_flip;
          r_b      <= in_rs2 ^ w_flip;
          r_f3     <= in_funct3;
          r_gt     <= 1'b0;
          r_lt     <= 1'b0;
          r_eq     <= 1'b1;
          r_idx    <= '0;
          in_ready <= 1'b0;
          r_state  <= BUSY;
        end
        BUSY: begin
          r_a   <= r_a >> SLICE;
          r_b   <= r_b >> SLICE;
          r_gt  <= w_gt;
          r_lt  <= w_lt;
          r_eq  <= w_eq;
          r_idx <= r_idx + 1'b1;
          if (r_idx == IW'(NSLICE - 1)) begin
            r_state     <= DONE;
            out_valid   <= 1'b1;
            out_taken   <= w_taken;
            out_illegal <= r_f3[2:1] == 2'b01;
            out_gt      <= w_gt;
            out_lt      <= w_lt;
            out_eq      <= w_eq;
          end
        end
        DONE: if (out_ready) begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_cmp_seq.sv
// tb_branch_cmp_seq: directed vectors with a queue scoreboard and decoupled result monitor
module tb_branch_cmp_seq;
  logic        clk = 0;
  logic        rst = 1;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [2:0]  in_funct3 = 0;
  logic [63:0] in_rs1 = 0;
  logic [63:0] in_rs2 = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic        out_taken, out_illegal, out_gt, out_lt, out_eq;

  branch_cmp_seq dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_illegal(out_illegal),
    .out_gt(out_gt), .out_lt(out_lt), .out_eq(out_eq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      n;
    logic [4:0] r;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // result word order: {taken, illegal, gt, lt, eq}
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got out_valid=1 expected no pending result");
      end else if (out_ready) begin
        exp_t e;
        e = q.pop_front();
        chk(e.n, {out_taken, out_illegal, out_gt, out_lt, out_eq}, e.r);
      end
    end
  end

  task automatic accept(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", in_ready, 1);
    in_valid = 1; in_funct3 = f3; in_rs1 = a; in_rs2 = b;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic run(input string name, input logic [2:0] f3, input logic [63:0] a,
                     input logic [63:0] b, input logic [4:0] r);
    int lat = 0;
    accept(f3, a, b);
    q.push_back('{name, r});
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, "_latency"}, lat, 4);
  endtask

  task automatic abort_test(input string name, input bit use_rst);
    accept(3'b000, 64'h1234, 64'h1234);
    @(posedge clk);
    #1 if (use_rst) rst = 1; else flush = 1;
    @(posedge clk);
    #1 begin rst = 0; flush = 0; end
    @(negedge clk);
    chk({name, "_idle"}, {in_ready, out_valid}, 2'b10);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk({name, "_no_valid"}, out_valid, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_state", {in_ready, out_valid, out_taken, out_illegal, out_gt, out_lt, out_eq}, 7'b1000000);

    run("beq_equal", 3'b000, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 5'b10001);
    run("blt_m1_1",  3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'b10010);
    run("bltu_m1_1", 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'b00100);
    run("bgeu_msb",  3'b111, 64'h0001_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 5'b10100);
    run("illegal",   3'b010, 64'h5, 64'h7, 5'b01010);
    run("bne_5_6",   3'b001, 64'h5, 64'h6, 5'b10010);

    @(posedge clk);
    #1 out_ready = 0;
    run("bge_stall", 3'b101, 64'd10, 64'hFFFF_FFFF_FFFF_FFFE, 5'b10100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", {out_valid, in_ready, out_taken, out_illegal, out_gt, out_lt, out_eq}, 7'b1010100);
    end
    @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("release_ready", {in_ready, out_valid}, 2'b10);

    abort_test("flush", 0);
    run("bge_after_flush", 3'b101, 64'd3, 64'd3, 5'b10001);
    abort_test("reset", 1);
    run("bge_after_rst", 3'b101, 64'd3, 64'd3, 5'b10001);

    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
